// File: rtl/os_frame_if.sv
// os_frame_if: sample stream and FFT-core handshake bundle for os_frame_builder; OS_FRAME_DROP_CNT_EN adds o_drop_cnt
interface os_frame_if #(parameter int W = 16);
  logic i_valid;
  logic signed [W-1:0] i_x_re;
  logic signed [W-1:0] i_x_im;
  logic o_ready;
  logic o_start;
  logic i_fft_ready;
  logic o_valid;
  logic signed [W-1:0] o_y_re;
  logic signed [W-1:0] o_y_im;
  logic o_last;
  logic [15:0] o_frame_cnt;
`ifdef OS_FRAME_DROP_CNT_EN
  logic [15:0] o_drop_cnt;
  modport slave (input i_valid, i_x_re, i_x_im, i_fft_ready,
                 output o_ready, o_start, o_valid, o_y_re, o_y_im, o_last, o_frame_cnt, o_drop_cnt);
  modport master (output i_valid, i_x_re, i_x_im, i_fft_ready,
                  input o_ready, o_start, o_valid, o_y_re, o_y_im, o_last, o_frame_cnt, o_drop_cnt);
`else
  modport slave (input i_valid, i_x_re, i_x_im, i_fft_ready,
                 output o_ready, o_start, o_valid, o_y_re, o_y_im, o_last, o_frame_cnt);
  modport master (output i_valid, i_x_re, i_x_im, i_fft_ready,
                  input o_ready, o_start, o_valid, o_y_re, o_y_im, o_last, o_frame_cnt);
`endif
endinterface

// File: rtl/os_frame_builder.sv
// os_frame_builder: 50% overlap-save framer feeding an FFT core; OS_FRAME_DROP_CNT_EN adds a saturating drop counter
module os_frame_builder #(
  parameter int NFFT = 32,
  parameter int W = 16
) (
  input logic i_clk,
  input logic i_rst,
  os_frame_if.slave bus
);
  localparam int H = NFFT / 2;
  localparam int AW = $clog2(H);
  localparam int SW = $clog2(NFFT);
  typedef enum logic [1:0] {S_FILL, S_START, S_SEND} state_t;
  state_t state;
  logic [AW-1:0] fill_cnt;
  logic [SW-1:0] send_cnt;
  logic wr_bank;
  logic hist_valid;
  logic signed [W-1:0] bank_re [2*H];
  logic signed [W-1:0] bank_im [2*H];
  logic hi;
  logic rd_bank;
  logic zero;
  assign bus.o_ready = state == S_FILL;
  assign bus.o_start = state == S_START;
  assign bus.o_valid = state == S_SEND;
  assign bus.o_last = bus.o_valid && send_cnt == SW'(NFFT - 1);
  always_comb begin
    hi = send_cnt[SW-1];
    rd_bank = hi ? wr_bank : ~wr_bank;
    zero = !bus.o_valid || (!hi && !hist_valid);
    bus.o_y_re = zero ? '0 : bank_re[{rd_bank, send_cnt[AW-1:0]}];
    bus.o_y_im = zero ? '0 : bank_im[{rd_bank, send_cnt[AW-1:0]}];
  end
  always_ff @(posedge i_clk)
    if (bus.i_valid && bus.o_ready) begin
      bank_re[{wr_bank, fill_cnt}] <= bus.i_x_re;
      bank_im[{wr_bank, fill_cnt}] <= bus.i_x_im;
    end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_FILL;
      fill_cnt <= '0;
      send_cnt <= '0;
      wr_bank <= 1'b0;
      hist_valid <= 1'b0;
      bus.o_frame_cnt <= '0;
    end else begin
      case (state)
        S_FILL: if (bus.i_valid) begin
          fill_cnt <= fill_cnt + 1'b1;
          if (fill_cnt == AW'(H - 1)) state <= S_START;
        end
        S_START: if (bus.i_fft_ready) state <= S_SEND;
        S_SEND: if (bus.i_fft_ready) begin
          send_cnt <= send_cnt + 1'b1;
          if (bus.o_last) begin
            wr_bank <= ~wr_bank;
            hist_valid <= 1'b1;
            bus.o_frame_cnt <= bus.o_frame_cnt + 16'd1;
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end
`ifdef OS_FRAME_DROP_CNT_EN
  always_ff @(posedge i_clk)
    if (i_rst) bus.o_drop_cnt <= '0;
    else if (bus.i_valid && !bus.o_ready && bus.o_drop_cnt != 16'hFFFF) bus.o_drop_cnt <= bus.o_drop_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_os_frame_builder.sv
// tb_os_frame_builder: randomized overlap-save framing checked against a sample-history model
module tb_os_frame_builder;
  localparam int NFFT = 8;
  localparam int W = 16;
  localparam int H = NFFT / 2;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  always #5 i_clk = ~i_clk;
  os_frame_if #(.W(W)) bus();
  os_frame_builder #(.NFFT(NFFT), .W(W)) dut (.i_clk(i_clk), .i_rst(i_rst), .bus(bus));
  int vectors = 0;
  int miscompares = 0;
  logic [2*W-1:0] all_q [$];
  int frames = 0;
  int drops = 0;
  function automatic logic [2*W-1:0] exp_sample(input int f, input int j);
    int idx;
    idx = f * H - H + j;
    return idx < 0 ? '0 : all_q[idx];
  endfunction
  task automatic run_frame(input int base, input int start_delay, input int stall_at,
                           input int stall_len, input bit keep_valid, input int rst_at);
    logic [2*W-1:0] s;
    logic [2*W-1:0] e;
    int j;
    int stalled;
    int f;
    bit xfer;
    f = frames;
    for (int i = 0; i < H; i++) begin
      @(negedge i_clk);
      if (base < 0)
        while ($urandom_range(3) == 0) begin
          bus.i_valid = 1'b0;
          @(negedge i_clk);
        end
      vectors++;
      if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL fill_ready: ready=%b valid=%b want 1/0", bus.o_ready, bus.o_valid);
      end
      s = base < 0 ? {16'($urandom), 16'($urandom)} : {16'(base + i), 16'd0};
      bus.i_valid = 1'b1;
      bus.i_x_re = s[2*W-1:W];
      bus.i_x_im = s[W-1:0];
      all_q.push_back(s);
    end
    for (int d = 0; d <= start_delay; d++) begin
      @(negedge i_clk);
      bus.i_valid = keep_valid;
      bus.i_x_re = 16'($urandom);
      if (keep_valid) drops++;
      vectors++;
      if (bus.o_start !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL start_phase: start=%b valid=%b ready=%b want 1/0/0", bus.o_start, bus.o_valid, bus.o_ready);
      end
      bus.i_fft_ready = d == start_delay;
    end
    j = 0;
    stalled = 0;
    while (j < NFFT) begin
      @(negedge i_clk);
      if (j == rst_at) begin
        i_rst = 1'b1;
        bus.i_valid = 1'b0;
        @(negedge i_clk);
        vectors++;
        if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_frame_cnt !== 16'd0) begin
          miscompares++;
          $display("FAIL mid_reset: valid=%b ready=%b cnt=%0d want 0/1/0", bus.o_valid, bus.o_ready, bus.o_frame_cnt);
        end
        i_rst = 1'b0;
        all_q.delete();
        frames = 0;
        drops = 0;
        return;
      end
      e = exp_sample(f, j);
      vectors++;
      if (bus.o_valid !== 1'b1 || bus.o_start !== 1'b0 || bus.o_ready !== 1'b0 ||
          {bus.o_y_re, bus.o_y_im} !== e || bus.o_last !== (j == NFFT - 1) || bus.o_frame_cnt !== 16'(f)) begin
        miscompares++;
        $display("FAIL send[%0d]: v=%b s=%b r=%b y=%h last=%b cnt=%0d want 1/0/0 y=%h last=%b cnt=%0d",
                 j, bus.o_valid, bus.o_start, bus.o_ready, {bus.o_y_re, bus.o_y_im}, bus.o_last,
                 bus.o_frame_cnt, e, j == NFFT - 1, f);
      end
      if (keep_valid) drops++;
      bus.i_x_re = 16'($urandom);
      xfer = !(j == stall_at && stalled < stall_len);
      if (!xfer) stalled++;
      bus.i_fft_ready = xfer;
      if (xfer) j++;
    end
    @(negedge i_clk);
    bus.i_valid = 1'b0;
    frames++;
    vectors++;
    if (bus.o_valid !== 1'b0 || bus.o_ready !== 1'b1 || bus.o_frame_cnt !== 16'(frames)) begin
      miscompares++;
      $display("FAIL frame_end: valid=%b ready=%b cnt=%0d want 0/1/%0d", bus.o_valid, bus.o_ready, bus.o_frame_cnt, frames);
    end
`ifdef OS_FRAME_DROP_CNT_EN
    vectors++;
    if (bus.o_drop_cnt !== 16'(drops)) begin
      miscompares++;
      $display("FAIL drop_cnt: got %0d want %0d", bus.o_drop_cnt, drops);
    end
`endif
  endtask
  task automatic test_reset();
    repeat (3) @(negedge i_clk);
    vectors++;
    if (bus.o_ready !== 1'b1 || bus.o_start !== 1'b0 || bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 ||
        bus.o_frame_cnt !== 16'd0 || bus.o_y_re !== '0 || bus.o_y_im !== '0) begin
      miscompares++;
      $display("FAIL reset_state: r=%b s=%b v=%b l=%b cnt=%0d y=%h want 1/0/0/0/0/0", bus.o_ready, bus.o_start,
               bus.o_valid, bus.o_last, bus.o_frame_cnt, {bus.o_y_re, bus.o_y_im});
    end
    i_rst = 1'b0;
  endtask
  task automatic test_directed();
    run_frame(1, 0, -1, 0, 1'b0, -1);
    run_frame(5, 0, -1, 0, 1'b0, -1);
    run_frame(9, 0, -1, 0, 1'b0, -1);
  endtask
  task automatic test_stalls();
    run_frame(-1, 5, 3, 3, 1'b0, -1);
    run_frame(-1, 2, 0, 2, 1'b0, -1);
  endtask
  task automatic test_drop();
    run_frame(-1, 0, -1, 0, 1'b1, -1);
    run_frame(-1, 1, 6, 1, 1'b1, -1);
  endtask
  task automatic test_reset_mid();
    run_frame(-1, 0, -1, 0, 1'b0, 2);
    run_frame(-1, 0, -1, 0, 1'b0, -1);
    run_frame(-1, 0, -1, 0, 1'b0, -1);
  endtask
  task automatic test_random();
    for (int k = 0; k < 12; k++)
      run_frame(-1, $urandom_range(3), $urandom_range(NFFT - 1), $urandom_range(3), 1'($urandom_range(1)), -1);
  endtask
  initial begin
    bus.i_valid = 1'b0;
    bus.i_x_re = '0;
    bus.i_x_im = '0;
    bus.i_fft_ready = 1'b0;
    test_reset();
    test_directed();
    test_stalls();
    test_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
